// File: rtl/axi_slave_pkg.sv
// Shared types and helpers for the AXI loop-back RAM responder.
// Burst encodings, response codes, FSM state encodings and the beat range rule.
package axi_slave_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10,
        BURST_RSVD  = 2'b11
    } burst_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef logic [1:0] wr_state_t;
    localparam wr_state_t W_IDLE = 2'd0;
    localparam wr_state_t W_DATA = 2'd1;
    localparam wr_state_t W_RESP = 2'd2;

    typedef logic [0:0] rd_state_t;
    localparam rd_state_t R_IDLE = 1'b0;
    localparam rd_state_t R_DATA = 1'b1;

    // A beat touches the RAM only for FIXED/INCR bursts landing inside the window.
    function automatic logic beat_valid(input logic [31:0] addr, input logic [31:0] base,
                                        input int unsigned depth_log2, input burst_t burst);
        logic [31:0] offset;
        offset = addr - base;
        return ((burst == BURST_FIXED) || (burst == BURST_INCR)) && (addr >= base) &&
               ((offset >> (depth_log2 + 2)) == 32'd0);
    endfunction

    function automatic logic [31:0] next_addr(input logic [31:0] addr, input burst_t burst);
        return (burst == BURST_INCR) ? addr + 32'd4 : addr;
    endfunction

endpackage

// File: rtl/axi_slave_dpram.sv
// Simple dual-port RAM: byte-enabled write port, registered read port, read-first.
module axi_slave_dpram #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [3:0]        be,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [31:0]       wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [31:0]       rdata
);

    logic [31:0] mem [0:(1 << ADDR_W)-1];

    // NOTE: the array has no reset so it maps onto block RAM and survives a reset pulse.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/axi_slave_ram.sv
// AXI responder backed by on-chip RAM; independent write and read channels.
module axi_slave_ram
    import axi_slave_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE  = 32'h0000_0000,
    parameter int unsigned DEPTH_LOG2 = 8
) (
    input  logic        SLAVE_CLK,
    input  logic        SLAVE_RSTN,
    input  logic [1:0]  SLAVE_WR_ADDR_ID,
    input  logic [31:0] SLAVE_WR_ADDR,
    input  logic [7:0]  SLAVE_WR_ADDR_LEN,
    input  logic [1:0]  SLAVE_WR_ADDR_BURST,
    input  logic        SLAVE_WR_ADDR_VALID,
    output logic        SLAVE_WR_ADDR_READY,
    input  logic [31:0] SLAVE_WR_DATA,
    input  logic [3:0]  SLAVE_WR_STRB,
    input  logic        SLAVE_WR_DATA_LAST,
    input  logic        SLAVE_WR_DATA_VALID,
    output logic        SLAVE_WR_DATA_READY,
    output logic [1:0]  SLAVE_WR_BACK_ID,
    output logic [1:0]  SLAVE_WR_BACK_RESP,
    output logic        SLAVE_WR_BACK_VALID,
    input  logic        SLAVE_WR_BACK_READY,
    input  logic [1:0]  SLAVE_RD_ADDR_ID,
    input  logic [31:0] SLAVE_RD_ADDR,
    input  logic [7:0]  SLAVE_RD_ADDR_LEN,
    input  logic [1:0]  SLAVE_RD_ADDR_BURST,
    input  logic        SLAVE_RD_ADDR_VALID,
    output logic        SLAVE_RD_ADDR_READY,
    output logic [1:0]  SLAVE_RD_BACK_ID,
    output logic [31:0] SLAVE_RD_DATA,
    output logic [1:0]  SLAVE_RD_DATA_RESP,
    output logic        SLAVE_RD_DATA_LAST,
    output logic        SLAVE_RD_DATA_VALID,
    input  logic        SLAVE_RD_DATA_READY
);

    // Holds both address channels off until the first clock after reset release.
    logic live;

    always_ff @(posedge SLAVE_CLK or negedge SLAVE_RSTN) begin
        if (!SLAVE_RSTN) live <= 1'b0;
        else             live <= 1'b1;
    end

    wr_state_t             wr_state;
    logic [1:0]            wr_id;
    logic [31:0]           wr_addr;
    logic [7:0]            wr_len;
    burst_t                wr_burst;
    logic [8:0]            wr_cnt;
    logic                  wr_err;
    logic                  aw_hs, w_hs, b_hs, wr_ok, wr_final;
    logic [DEPTH_LOG2-1:0] wr_idx;

    assign SLAVE_WR_ADDR_READY = live && (wr_state == W_IDLE);
    assign SLAVE_WR_DATA_READY = (wr_state == W_DATA);
    assign SLAVE_WR_BACK_VALID = (wr_state == W_RESP);
    assign SLAVE_WR_BACK_ID    = wr_id;
    assign SLAVE_WR_BACK_RESP  = wr_err ? RESP_SLVERR : RESP_OKAY;

    assign aw_hs    = SLAVE_WR_ADDR_VALID && SLAVE_WR_ADDR_READY;
    assign w_hs     = SLAVE_WR_DATA_VALID && SLAVE_WR_DATA_READY;
    assign b_hs     = SLAVE_WR_BACK_VALID && SLAVE_WR_BACK_READY;
    assign wr_ok    = beat_valid(wr_addr, ADDR_BASE, DEPTH_LOG2, wr_burst);
    assign wr_final = (wr_cnt == {1'b0, wr_len});
    assign wr_idx   = DEPTH_LOG2'((wr_addr - ADDR_BASE) >> 2);

    always_ff @(posedge SLAVE_CLK or negedge SLAVE_RSTN) begin
        if (!SLAVE_RSTN) begin
            wr_state <= W_IDLE;
            wr_id    <= '0;
            wr_addr  <= '0;
            wr_len   <= '0;
            wr_burst <= BURST_FIXED;
            wr_cnt   <= '0;
            wr_err   <= 1'b0;
        end else begin
            case (wr_state)
                W_IDLE: if (aw_hs) begin
                    wr_id    <= SLAVE_WR_ADDR_ID;
                    wr_addr  <= SLAVE_WR_ADDR;
                    wr_len   <= SLAVE_WR_ADDR_LEN;
                    wr_burst <= burst_t'(SLAVE_WR_ADDR_BURST);
                    wr_cnt   <= '0;
                    wr_err   <= 1'b0;
                    wr_state <= W_DATA;
                end
                // The burst length is fixed by AW; a misplaced or missing LAST only flags an error.
                W_DATA: if (w_hs) begin
                    wr_addr <= next_addr(wr_addr, wr_burst);
                    wr_cnt  <= wr_cnt + 9'd1;
                    if (!wr_ok || (SLAVE_WR_DATA_LAST != wr_final)) wr_err <= 1'b1;
                    if (wr_final) wr_state <= W_RESP;
                end
                W_RESP: if (b_hs) wr_state <= W_IDLE;
                default: wr_state <= W_IDLE;
            endcase
        end
    end

    rd_state_t             rd_state;
    logic [1:0]            rd_id;
    logic [31:0]           rd_addr;
    logic [7:0]            rd_len;
    burst_t                rd_burst;
    logic [8:0]            rd_issued;
    logic                  ar_hs, r_hs, issue, advance, rd_ok;
    logic [DEPTH_LOG2-1:0] rd_idx;
    logic                  a_valid, a_err, a_last;
    logic [31:0]           ram_q;
    logic                  r_valid, r_last;
    logic [1:0]            r_resp;
    logic [31:0]           r_data;

    assign SLAVE_RD_ADDR_READY = live && (rd_state == R_IDLE);
    assign SLAVE_RD_BACK_ID    = rd_id;
    assign SLAVE_RD_DATA       = r_data;
    assign SLAVE_RD_DATA_RESP  = r_resp;
    assign SLAVE_RD_DATA_LAST  = r_last;
    assign SLAVE_RD_DATA_VALID = r_valid;

    assign ar_hs   = SLAVE_RD_ADDR_VALID && SLAVE_RD_ADDR_READY;
    assign r_hs    = r_valid && SLAVE_RD_DATA_READY;
    // Two-stage pipe (RAM register, output register) that freezes as a whole on a stall.
    assign advance = !r_valid || SLAVE_RD_DATA_READY;
    assign issue   = (rd_state == R_DATA) && (rd_issued <= {1'b0, rd_len});
    assign rd_ok   = beat_valid(rd_addr, ADDR_BASE, DEPTH_LOG2, rd_burst);
    assign rd_idx  = DEPTH_LOG2'((rd_addr - ADDR_BASE) >> 2);

    always_ff @(posedge SLAVE_CLK or negedge SLAVE_RSTN) begin
        if (!SLAVE_RSTN) begin
            rd_state  <= R_IDLE;
            rd_id     <= '0;
            rd_addr   <= '0;
            rd_len    <= '0;
            rd_burst  <= BURST_FIXED;
            rd_issued <= '0;
        end else if (rd_state == R_IDLE) begin
            if (ar_hs) begin
                rd_id     <= SLAVE_RD_ADDR_ID;
                rd_addr   <= SLAVE_RD_ADDR;
                rd_len    <= SLAVE_RD_ADDR_LEN;
                rd_burst  <= burst_t'(SLAVE_RD_ADDR_BURST);
                rd_issued <= '0;
                rd_state  <= R_DATA;
            end
        end else begin
            if (issue && advance) begin
                rd_addr   <= next_addr(rd_addr, rd_burst);
                rd_issued <= rd_issued + 9'd1;
            end
            if (r_hs && r_last) rd_state <= R_IDLE;
        end
    end

    always_ff @(posedge SLAVE_CLK or negedge SLAVE_RSTN) begin
        if (!SLAVE_RSTN) begin
            a_valid <= 1'b0;
            a_err   <= 1'b0;
            a_last  <= 1'b0;
            r_valid <= 1'b0;
            r_data  <= '0;
            r_resp  <= RESP_OKAY;
            r_last  <= 1'b0;
        end else if (advance) begin
            a_valid <= issue;
            a_err   <= !rd_ok;
            a_last  <= (rd_issued == {1'b0, rd_len});
            r_valid <= a_valid;
            r_data  <= a_err ? 32'd0 : ram_q;
            r_resp  <= a_err ? RESP_SLVERR : RESP_OKAY;
            r_last  <= a_valid && a_last;
        end
    end

    axi_slave_dpram #(
        .ADDR_W(DEPTH_LOG2)
    ) u_ram (
        .clk   (SLAVE_CLK),
        .rst_n (SLAVE_RSTN),
        .we    (w_hs && wr_ok),
        .be    (SLAVE_WR_STRB),
        .waddr (wr_idx),
        .wdata (SLAVE_WR_DATA),
        .re    (issue && advance),
        .raddr (rd_idx),
        .rdata (ram_q)
    );

endmodule

// File: tb/tb_axi_slave_ram.sv
// Self-checking bench for axi_slave_ram: directed bursts plus random traffic
// compared against a word-array model of the RAM and the burst rules.
module tb_axi_slave_ram;

    localparam logic [31:0] BASE       = 32'h1000_0000;
    localparam int          DEPTH_LOG2 = 8;
    localparam int          DEPTH      = 1 << DEPTH_LOG2;
    localparam int          TMO        = 64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  aw_id, aw_burst, ar_id, ar_burst;
    logic [31:0] aw_addr, ar_addr, w_data;
    logic [7:0]  aw_len, ar_len;
    logic        aw_valid, aw_ready, w_last, w_valid, w_ready, b_valid, b_ready;
    logic        ar_valid, ar_ready, r_last, r_valid, r_ready;
    logic [3:0]  w_strb;
    logic [1:0]  b_id, b_resp, r_id, r_resp;
    logic [31:0] r_data;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] mdl [DEPTH];
    logic [31:0] wd [256];
    logic [3:0]  ws [256];

    always #5 clk = ~clk;

    axi_slave_ram #(.ADDR_BASE(BASE), .DEPTH_LOG2(DEPTH_LOG2)) dut (
        .SLAVE_CLK(clk), .SLAVE_RSTN(rst_n),
        .SLAVE_WR_ADDR_ID(aw_id), .SLAVE_WR_ADDR(aw_addr), .SLAVE_WR_ADDR_LEN(aw_len),
        .SLAVE_WR_ADDR_BURST(aw_burst), .SLAVE_WR_ADDR_VALID(aw_valid), .SLAVE_WR_ADDR_READY(aw_ready),
        .SLAVE_WR_DATA(w_data), .SLAVE_WR_STRB(w_strb), .SLAVE_WR_DATA_LAST(w_last),
        .SLAVE_WR_DATA_VALID(w_valid), .SLAVE_WR_DATA_READY(w_ready),
        .SLAVE_WR_BACK_ID(b_id), .SLAVE_WR_BACK_RESP(b_resp), .SLAVE_WR_BACK_VALID(b_valid),
        .SLAVE_WR_BACK_READY(b_ready),
        .SLAVE_RD_ADDR_ID(ar_id), .SLAVE_RD_ADDR(ar_addr), .SLAVE_RD_ADDR_LEN(ar_len),
        .SLAVE_RD_ADDR_BURST(ar_burst), .SLAVE_RD_ADDR_VALID(ar_valid), .SLAVE_RD_ADDR_READY(ar_ready),
        .SLAVE_RD_BACK_ID(r_id), .SLAVE_RD_DATA(r_data), .SLAVE_RD_DATA_RESP(r_resp),
        .SLAVE_RD_DATA_LAST(r_last), .SLAVE_RD_DATA_VALID(r_valid), .SLAVE_RD_DATA_READY(r_ready)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] beat_addr(input logic [31:0] a, input logic [1:0] b, input int k);
        return (b == 2'b01) ? a + 32'(4 * k) : a;
    endfunction

    function automatic bit in_ram(input logic [31:0] a, input logic [1:0] b);
        return (b <= 2'b01) && (a >= BASE) && ((a - BASE) < 32'(DEPTH * 4));
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((a - BASE) >> 2);
    endfunction

    function automatic logic [63:0] all_outputs();
        return 64'({aw_ready, w_ready, b_id, b_resp, b_valid, ar_ready,
                    r_id, r_data, r_resp, r_last, r_valid});
    endfunction

    task automatic aw_send(input logic [1:0] id, input logic [31:0] a, input int len, input logic [1:0] b);
        int t = 0;
        aw_id = id; aw_addr = a; aw_len = 8'(len); aw_burst = b; aw_valid = 1'b1;
        while (!aw_ready && t < TMO) begin @(negedge clk); t++; end
        check("aw_ready_wait", 64'(t < TMO), 64'd1);
        @(negedge clk);
        aw_valid = 1'b0;
    endtask

    task automatic ar_send(input logic [1:0] id, input logic [31:0] a, input int len, input logic [1:0] b);
        int t = 0;
        ar_id = id; ar_addr = a; ar_len = 8'(len); ar_burst = b; ar_valid = 1'b1;
        while (!ar_ready && t < TMO) begin @(negedge clk); t++; end
        check("ar_ready_wait", 64'(t < TMO), 64'd1);
        @(negedge clk);
        ar_valid = 1'b0;
    endtask

    task automatic w_beat(input logic [31:0] d, input logic [3:0] s, input bit last);
        int t = 0;
        w_data = d; w_strb = s; w_last = last; w_valid = 1'b1;
        while (!w_ready && t < TMO) begin @(negedge clk); t++; end
        check("w_ready_wait", 64'(t < TMO), 64'd1);
        @(negedge clk);
        w_valid = 1'b0;
    endtask

    // Model side of a write beat: store strobed bytes if the beat lands in RAM.
    task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                               input logic [1:0] b, output bit err);
        err = !in_ram(a, b);
        if (!err) begin
            for (int i = 0; i < 4; i++) if (s[i]) mdl[widx(a)][8*i +: 8] = d[8*i +: 8];
        end
    endtask

    task automatic wr_burst(input logic [1:0] id, input logic [31:0] a, input int len,
                            input logic [1:0] b, input int last_at);
        bit err = 0;
        bit beat_err;
        int t = 0;
        aw_send(id, a, len, b);
        for (int k = 0; k <= len; k++) begin
            w_beat(wd[k], ws[k], k == last_at);
            model_write(beat_addr(a, b, k), wd[k], ws[k], b, beat_err);
            if (beat_err || ((k == last_at) != (k == len))) err = 1;
        end
        b_ready = 1'b1;
        while (!b_valid && t < TMO) begin @(negedge clk); t++; end
        check("b_valid_wait", 64'(t < TMO), 64'd1);
        check("b_id", 64'(b_id), 64'(id));
        check("b_resp", 64'(b_resp), err ? 64'h2 : 64'h0);
        @(negedge clk);
        b_ready = 1'b0;
        check("b_valid_drop", 64'(b_valid), 64'd0);
    endtask

    task automatic rd_burst(input logic [1:0] id, input logic [31:0] a, input int len,
                            input logic [1:0] b, input int stall_pct);
        int k = 0, cyc = 0;
        bit prev_stall = 0, prev_go = 0, seen = 0, rr;
        logic [31:0] ak, ed;
        logic [1:0]  er;
        ar_send(id, a, len, b);
        while (k <= len && cyc < 4 * (len + 1) + TMO) begin
            rr = ($urandom_range(99, 0) >= 32'(stall_pct));
            r_ready = rr;
            ak = beat_addr(a, b, k);
            if (in_ram(ak, b)) begin ed = mdl[widx(ak)]; er = 2'b00; end
            else               begin ed = 32'd0;         er = 2'b10; end
            if (prev_stall || prev_go) check("r_valid_continuous", 64'(r_valid), 64'd1);
            if (r_valid) begin
                if (!seen) begin check("r_first_latency", 64'(cyc), 64'd2); seen = 1; end
                check("r_data", 64'(r_data), 64'(ed));
                check("r_resp", 64'(r_resp), 64'(er));
                check("r_last", 64'(r_last), 64'(k == len));
                check("r_id", 64'(r_id), 64'(id));
            end
            prev_stall = r_valid && !rr;
            prev_go    = r_valid && rr && (k != len);
            if (r_valid && rr) k++;
            @(negedge clk);
            cyc++;
        end
        r_ready = 1'b0;
        check("r_beat_count", 64'(k), 64'(len + 1));
        check("r_valid_after_last", 64'(r_valid), 64'd0);
        check("ar_ready_after_last", 64'(ar_ready), 64'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          dummy;
        int          len, last_at, rlen;
        logic [1:0]  bt, rbt;
        logic [31:0] a;

        rst_n = 1'b0;
        aw_id = '0; aw_addr = '0; aw_len = '0; aw_burst = '0; aw_valid = 1'b0;
        w_data = '0; w_strb = '0; w_last = 1'b0; w_valid = 1'b0; b_ready = 1'b0;
        ar_id = '0; ar_addr = '0; ar_len = '0; ar_burst = '0; ar_valid = 1'b0; r_ready = 1'b0;

        // Reset state and ready release timing.
        repeat (2) @(negedge clk);
        check("reset_outputs", all_outputs(), 64'd0);
        rst_n = 1'b1;
        #1 check("aw_ready_at_release", 64'(aw_ready), 64'd0);
        @(negedge clk);
        check("aw_ready_after_release", 64'(aw_ready), 64'd1);
        check("ar_ready_after_release", 64'(ar_ready), 64'd1);

        // 1: INCR write 1..4 then INCR read back.
        for (int k = 0; k < 4; k++) begin wd[k] = 32'(k + 1); ws[k] = 4'hF; end
        wr_burst(2'd2, BASE, 3, 2'b01, 3);
        rd_burst(2'd1, BASE, 3, 2'b01, 0);

        // 2: partial strobes over a zeroed word.
        wd[0] = 32'd0; ws[0] = 4'hF;
        wr_burst(2'd0, BASE + 32'd16, 0, 2'b01, 0);
        wd[0] = 32'hAABB_CCDD; ws[0] = 4'b0101;
        wr_burst(2'd3, BASE + 32'd16, 0, 2'b01, 0);
        check("strobe_model_word", 64'(mdl[4]), 64'h00BB_00DD);
        rd_burst(2'd0, BASE + 32'd16, 0, 2'b01, 0);

        // 3: FIXED write keeps the last beat; FIXED read repeats it.
        wd[0] = 32'd5; wd[1] = 32'd6; wd[2] = 32'd7;
        ws[0] = 4'hF;  ws[1] = 4'hF;  ws[2] = 4'hF;
        wr_burst(2'd1, BASE + 32'd32, 2, 2'b00, 2);
        rd_burst(2'd2, BASE + 32'd32, 0, 2'b01, 0);
        rd_burst(2'd2, BASE + 32'd32, 2, 2'b00, 0);

        // 4: bursts straddling the top and bottom of the window, and unsupported burst types.
        wd[0] = $urandom(); wd[1] = $urandom(); ws[0] = 4'hF; ws[1] = 4'hF;
        wr_burst(2'd3, BASE + 32'(4 * (DEPTH - 1)), 1, 2'b01, 1);
        rd_burst(2'd3, BASE + 32'(4 * (DEPTH - 1)), 1, 2'b01, 0);
        wd[0] = $urandom(); wd[1] = $urandom();
        wr_burst(2'd1, BASE - 32'd4, 1, 2'b01, 1);
        rd_burst(2'd1, BASE - 32'd4, 1, 2'b01, 0);
        wr_burst(2'd2, BASE + 32'd64, 1, 2'b10, 1);
        rd_burst(2'd2, BASE + 32'd64, 1, 2'b10, 0);
        rd_burst(2'd0, BASE, 0, 2'b11, 0);

        // 5: fill the whole RAM with one 256-beat write, read it back under stalls.
        for (int k = 0; k < 256; k++) begin wd[k] = $urandom(); ws[k] = 4'hF; end
        wr_burst(2'd0, BASE, 255, 2'b01, 255);
        rd_burst(2'd3, BASE, 255, 2'b01, 30);
        rd_burst(2'd1, BASE, 255, 2'b01, 0);

        // 6: reset in the middle of a write burst; RAM contents survive.
        aw_send(2'd1, BASE + 32'd128, 3, 2'b01);
        for (int k = 0; k < 2; k++) begin
            wd[k] = $urandom();
            w_beat(wd[k], 4'hF, 1'b0);
            model_write(BASE + 32'd128 + 32'(4 * k), wd[k], 4'hF, 2'b01, dummy);
        end
        rst_n = 1'b0;
        #1 check("reset_mid_burst_outputs", all_outputs(), 64'd0);
        repeat (2) @(negedge clk);
        check("reset_held_outputs", all_outputs(), 64'd0);
        rst_n = 1'b1;
        #1 check("aw_ready_at_rerelease", 64'(aw_ready), 64'd0);
        @(negedge clk);
        check("aw_ready_after_rerelease", 64'(aw_ready), 64'd1);
        rd_burst(2'd2, BASE, 255, 2'b01, 20);

        // Early LAST on beat 2 of a 4-beat burst: all beats still land, SLVERR.
        for (int k = 0; k < 4; k++) begin wd[k] = $urandom(); ws[k] = 4'(k + 9); end
        wr_burst(2'd2, BASE + 32'd800, 3, 2'b01, 1);
        rd_burst(2'd2, BASE + 32'd800, 3, 2'b01, 0);

        // Random bursts around and inside the window.
        for (int n = 0; n < 24; n++) begin
            len = int'($urandom_range(15, 0));
            case ($urandom_range(9, 0))
                0:       bt = 2'b10;
                1:       bt = 2'b11;
                2, 3, 4: bt = 2'b00;
                default: bt = 2'b01;
            endcase
            a = BASE - 32'd64 + $urandom_range(DEPTH * 4 + 128, 0);
            last_at = ($urandom_range(7, 0) == 0) ? int'($urandom_range(len + 1, 0)) : len;
            for (int k = 0; k <= len; k++) begin wd[k] = $urandom(); ws[k] = 4'($urandom()); end
            wr_burst(2'($urandom()), a, len, bt, last_at);
            rlen = int'($urandom_range(20, 0));
            rbt  = ($urandom_range(3, 0) == 0) ? 2'b00 : 2'b01;
            rd_burst(2'($urandom()), a - 32'd8, rlen, rbt, 25);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
